// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic job arbiter and its surroundings.
//   arb_state_t : arbiter FSM states
//   SIZE_D, WIDTH_D, WIDTHX_D : default matrix dimension and element widths
//   a_elem_t, c_elem_t : operand and product element types at default widths
package systolic_pkg;

    localparam int SIZE_D   = 32;
    localparam int WIDTH_D  = 16;
    localparam int WIDTHX_D = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    typedef logic [WIDTHX_D-1:0] a_elem_t;
    typedef logic [WIDTH_D-1:0]  c_elem_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req        : request vector
//   last_grant : index granted last; the scan starts one above it
//   enable     : when low no grant is issued
//   grant      : one-hot grant (zero when disabled or nothing requested)
//   grant_idx  : index of the winner (meaningful only when grant != 0)
module rr_arbiter
    import systolic_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] sel;

    // NOTE: every output and intermediate gets a default first, so no path
    // through the block can hold an old value and infer a latch.
    always_comb begin
        hi_req    = '0;
        grant     = '0;
        grant_idx = '0;
        // Requests strictly above the last winner have priority; if none,
        // wrap around and take the lowest request overall.
        for (int i = 0; i < NREQ; i++) begin
            hi_req[i] = req[i] && (i > int'(last_grant));
        end
        sel = (|hi_req) ? hi_req : req;
        // Downward scan: the last hit is the lowest set bit.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (sel[i]) grant_idx = IW'(i);
        end
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = enable && (|sel) && (grant_idx == IW'(i));
        end
    end

endmodule

// File: rtl/systolic_job_arbiter.sv
// Round-robin job arbiter/sequencer in front of one shared systolic array.
//   clock, reset          : single clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester job handshake (ready is one-hot)
//   req_a, req_b          : per-requester operand matrices
//   rsp_valid/rsp_ready   : per-requester result handshake (valid is one-hot)
//   rsp_c, rsp_error      : shared result matrix, timeout-abort flag
//   mm_valid_o/mm_ready_i : handshake to the array
//   mm_a_o, mm_b_o, mm_c_i: latched operands to / product from the array
//   busy_o, grant_id_o    : FSM not idle, requester owning the array
module systolic_job_arbiter
    import systolic_pkg::*;
#(
    parameter  int NREQ    = 2,
    parameter  int SIZE    = SIZE_D,
    parameter  int WIDTHx  = WIDTHX_D,
    parameter  int WIDTH   = WIDTH_D,
    parameter  int TIMEOUT = 1024,
    localparam int IW      = $clog2(NREQ),
    localparam int CW      = $clog2(TIMEOUT)
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [NREQ-1:0]                               req_valid,
    output logic [NREQ-1:0]                               req_ready,
    input  logic [NREQ-1:0][SIZE-1:0][SIZE-1:0][WIDTHx-1:0] req_a,
    input  logic [NREQ-1:0][SIZE-1:0][SIZE-1:0][WIDTHx-1:0] req_b,
    output logic [NREQ-1:0]                               rsp_valid,
    input  logic [NREQ-1:0]                               rsp_ready,
    output logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]          rsp_c,
    output logic                                          rsp_error,
    output logic                                          mm_valid_o,
    input  logic                                          mm_ready_i,
    output logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0]         mm_a_o,
    output logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0]         mm_b_o,
    input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]          mm_c_i,
    output logic                                          busy_o,
    output logic [IW-1:0]                                 grant_id_o
);

    arb_state_t    state, state_next;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] win_idx;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          timeout_hit;

    // Reset gates the grant so req_ready reads 0 while reset is held.
    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .enable     ((state == IDLE) && !reset),
        .grant      (req_ready),
        .grant_idx  (win_idx)
    );

    assign accept      = |(req_valid & req_ready);
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        mm_valid_o = 1'b0;
        rsp_valid  = '0;
        busy_o     = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) state_next = ISSUE;
            end
            ISSUE: begin
                mm_valid_o = 1'b1;
                if (mm_ready_i || timeout_hit) state_next = RESP;
            end
            RESP: begin
                for (int i = 0; i < NREQ; i++) begin
                    rsp_valid[i] = (grant_id_o == IW'(i));
                end
                // Only the owner's rsp_ready can close the job.
                if (rsp_ready[grant_id_o]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the wide operand/result registers are reset too, because they
    // drive outputs whose reset value must be all zeros.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= IW'(NREQ - 1);
            grant_id_o <= '0;
            cnt        <= '0;
            mm_a_o     <= '0;
            mm_b_o     <= '0;
            rsp_c      <= '0;
            rsp_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mm_a_o     <= req_a[win_idx];
                        mm_b_o     <= req_b[win_idx];
                        grant_id_o <= win_idx;
                        last_grant <= win_idx;
                        cnt        <= '0;
                    end
                end
                ISSUE: begin
                    // A result arriving on the timeout cycle still wins.
                    if (mm_ready_i) begin
                        rsp_c     <= mm_c_i;
                        rsp_error <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_c     <= '0;
                        rsp_error <= 1'b1;
                    end else if (!(&cnt)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_job_arbiter.sv
// Directed bench for systolic_job_arbiter with a behavioural array stub and
// an expected-result queue filled as jobs are offered.
module tb_systolic_job_arbiter;
    import systolic_pkg::*;

    localparam int NREQ = 2;
    localparam int SIZE = 4;
    localparam int WX   = WIDTHX_D;
    localparam int W    = WIDTH_D;
    localparam int TO   = 100;
    localparam int IW   = $clog2(NREQ);
    localparam int CB   = SIZE * SIZE * W;

    typedef a_elem_t [SIZE-1:0][SIZE-1:0] amat_t;
    typedef c_elem_t [SIZE-1:0][SIZE-1:0] cmat_t;

    typedef struct {
        int    id;
        cmat_t c;
        logic  err;
    } exp_t;

    logic              clock;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    amat_t [NREQ-1:0]  req_a;
    amat_t [NREQ-1:0]  req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    cmat_t             rsp_c;
    logic              rsp_error;
    logic              mm_valid_o;
    logic              mm_ready_i;
    amat_t             mm_a_o;
    amat_t             mm_b_o;
    cmat_t             mm_c_i;
    logic              busy_o;
    logic [IW-1:0]     grant_id_o;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    bit   stub_en  = 1'b0;
    int   stub_lat = 3;
    int   stub_cnt = 0;

    systolic_job_arbiter #(
        .NREQ(NREQ), .SIZE(SIZE), .WIDTHx(WX), .WIDTH(W), .TIMEOUT(TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_c      (rsp_c),
        .rsp_error  (rsp_error),
        .mm_valid_o (mm_valid_o),
        .mm_ready_i (mm_ready_i),
        .mm_a_o     (mm_a_o),
        .mm_b_o     (mm_b_o),
        .mm_c_i     (mm_c_i),
        .busy_o     (busy_o),
        .grant_id_o (grant_id_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic cmat_t matmul(input amat_t a, input amat_t b);
        cmat_t c;
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                c[i][j] = '0;
                for (int k = 0; k < SIZE; k++) begin
                    c[i][j] = c[i][j] + c_elem_t'(a[i][k]) * c_elem_t'(b[k][j]);
                end
            end
        end
        return c;
    endfunction

    function automatic amat_t rand_mat();
        amat_t m;
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                m[i][j] = a_elem_t'($urandom_range(0, 15));
        return m;
    endfunction

    function automatic amat_t fill_mat(input int v, input bit diag_only);
        amat_t m;
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                m[i][j] = (!diag_only || i == j) ? a_elem_t'(v) : a_elem_t'(0);
        return m;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int id);
        logic [NREQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [CB-1:0] obs, input logic [CB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Array stub: answers stub_lat cycles into each valid run, with the true
    // product of the operands it sees; junk on mm_c_i otherwise.
    always @(posedge clock) begin
        #1;
        if (!stub_en || !mm_valid_o) begin
            stub_cnt   = 0;
            mm_ready_i = 1'b0;
            mm_c_i     = cmat_t'({(SIZE * SIZE){16'hBEEF}});
        end else begin
            stub_cnt++;
            if (stub_cnt == stub_lat) begin
                mm_ready_i = 1'b1;
                mm_c_i     = matmul(mm_a_o, mm_b_o);
            end else begin
                mm_ready_i = 1'b0;
                mm_c_i     = cmat_t'({(SIZE * SIZE){16'hBEEF}});
            end
        end
    end

    // Grants and responses are one-hot, and no grant is offered while busy.
    always @(negedge clock) begin
        if (!reset) begin
            check("invariants",
                  CB'({$onehot0(req_ready), $onehot0(rsp_valid), (req_ready == '0) || !busy_o}),
                  CB'(3'b111));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic wait_rsp(input string tag, output cmat_t c_exp);
        int   n;
        exp_t e;
        n     = 0;
        c_exp = '0;
        while (rsp_valid == '0 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_arrived"}, CB'(rsp_valid != '0), CB'(1'b1));
        check({tag, "_sb_nonempty"}, CB'(sb.size() != 0), CB'(1'b1));
        if (sb.size() != 0) begin
            e     = sb.pop_front();
            c_exp = e.c;
            check({tag, "_rsp_valid"}, CB'(rsp_valid), CB'(oh(e.id)));
            check({tag, "_rsp_c"}, CB'(rsp_c), CB'(e.c));
            check({tag, "_rsp_error"}, CB'(rsp_error), CB'(e.err));
            check({tag, "_mm_valid_low"}, CB'(mm_valid_o), CB'(1'b0));
        end
    endtask

    task automatic rsp_hs(input string tag, input int id);
        rsp_ready = oh(id);
        tick();
        rsp_ready = '0;
        check({tag, "_rsp_dropped"}, CB'(rsp_valid), CB'(0));
        check({tag, "_idle"}, CB'(busy_o), CB'(1'b0));
    endtask

    initial begin
        cmat_t c_exp;
        amat_t a_keep;

        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) tick();

        // Reset values
        check("rst_req_ready", CB'(req_ready), CB'(0));
        check("rst_rsp_valid", CB'(rsp_valid), CB'(0));
        check("rst_rsp_c", CB'(rsp_c), CB'(0));
        check("rst_rsp_error", CB'(rsp_error), CB'(0));
        check("rst_mm_valid", CB'(mm_valid_o), CB'(0));
        check("rst_mm_a", CB'(mm_a_o), CB'(0));
        check("rst_busy", CB'(busy_o), CB'(0));
        check("rst_grant_id", CB'(grant_id_o), CB'(0));
        reset = 1'b0;

        // Single job: identity x all-3, array latency 3
        stub_en  = 1'b1;
        stub_lat = 3;
        req_a[0] = fill_mat(1, 1'b1);
        req_b[0] = fill_mat(3, 1'b0);
        req_valid = 2'b01;
        sb.push_back('{id: 0, c: matmul(req_a[0], req_b[0]), err: 1'b0});
        #1;
        check("t1_req_ready", CB'(req_ready), CB'(2'b01));
        tick();
        check("t1_mm_valid_rise", CB'(mm_valid_o), CB'(1'b1));
        check("t1_grant_id", CB'(grant_id_o), CB'(0));
        check("t1_no_ready_busy", CB'(req_ready), CB'(0));
        req_valid = '0;
        tick();
        check("t1_wait1", CB'(rsp_valid), CB'(0));
        tick();
        check("t1_wait2", CB'(rsp_valid), CB'(0));
        tick();
        check("t1_rsp_at_R1", CB'(rsp_valid), CB'(2'b01));
        wait_rsp("t1", c_exp);
        check("t1_all3", CB'(rsp_c), CB'(matmul(fill_mat(1, 1'b0), fill_mat(1, 1'b0)) * 0 | cmat_t'({(SIZE * SIZE){16'd3}})));
        rsp_hs("t1", 0);

        // Timeout on requester 1 with a silent array
        stub_en  = 1'b0;
        req_a[1] = rand_mat();
        req_b[1] = rand_mat();
        req_valid = 2'b10;
        sb.push_back('{id: 1, c: '0, err: 1'b1});
        #1;
        check("t4_req_ready", CB'(req_ready), CB'(2'b10));
        tick();
        req_valid = '0;
        repeat (TO - 1) tick();
        check("t4_no_rsp_before", CB'(rsp_valid), CB'(0));
        check("t4_still_issue", CB'(mm_valid_o), CB'(1'b1));
        tick();
        check("t4_rsp_at_T101", CB'(rsp_valid), CB'(2'b10));
        wait_rsp("t4", c_exp);
        rsp_hs("t4", 1);
        stub_en = 1'b1;

        // Both requesters continuously valid: 0,1,0,1
        stub_lat = 2;
        for (int r = 0; r < NREQ; r++) begin
            req_a[r] = rand_mat();
            req_b[r] = rand_mat();
        end
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            #1;
            check($sformatf("t2_grant%0d", j), CB'(req_ready), CB'(oh(j % 2)));
            sb.push_back('{id: j % 2, c: matmul(req_a[j % 2], req_b[j % 2]), err: 1'b0});
            tick();
            req_a[j % 2] = rand_mat();
            req_b[j % 2] = rand_mat();
            wait_rsp($sformatf("t2_job%0d", j), c_exp);
            rsp_hs($sformatf("t2_job%0d", j), j % 2);
            if (j == 3) req_valid = '0;
        end

        // Operand stability while the requester changes its inputs
        stub_lat = 8;
        req_a[0] = rand_mat();
        req_b[0] = rand_mat();
        a_keep   = req_a[0];
        req_valid = 2'b01;
        sb.push_back('{id: 0, c: matmul(req_a[0], req_b[0]), err: 1'b0});
        tick();
        req_valid = '0;
        tick();
        req_a[0] = fill_mat(15, 1'b0);
        tick();
        check("t3_mm_a_hold1", CB'(mm_a_o), CB'(a_keep));
        repeat (3) tick();
        check("t3_mm_a_hold2", CB'(mm_a_o), CB'(a_keep));
        check("t3_in_issue", CB'(mm_valid_o), CB'(1'b1));
        wait_rsp("t3", c_exp);
        rsp_hs("t3", 0);

        // Backpressure on the response while requester 1 waits
        stub_lat = 2;
        req_a[0] = rand_mat();
        req_b[0] = rand_mat();
        req_valid = 2'b01;
        sb.push_back('{id: 0, c: matmul(req_a[0], req_b[0]), err: 1'b0});
        tick();
        req_valid = '0;
        wait_rsp("t5", c_exp);
        req_a[1] = rand_mat();
        req_b[1] = rand_mat();
        req_valid = 2'b10;
        for (int k = 0; k < 20; k++) begin
            rsp_ready = (k == 10) ? 2'b10 : 2'b00;
            tick();
            check($sformatf("t5_c_stable%0d", k), CB'(rsp_c), CB'(c_exp));
            check($sformatf("t5_no_grant%0d", k), CB'(req_ready), CB'(0));
            check($sformatf("t5_rsp_held%0d", k), CB'(rsp_valid), CB'(2'b01));
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;
        #1;
        check("t5_grant1_at_S1", CB'(req_ready), CB'(2'b10));
        sb.push_back('{id: 1, c: matmul(req_a[1], req_b[1]), err: 1'b0});
        tick();
        req_valid = '0;
        check("t5_grant_id1", CB'(grant_id_o), CB'(1));
        wait_rsp("t5b", c_exp);
        rsp_hs("t5b", 1);

        // Reset in the middle of ISSUE drops the job
        stub_en  = 1'b0;
        req_a[0] = rand_mat();
        req_b[0] = rand_mat();
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        repeat (5) tick();
        check("t6_issue_before", CB'(mm_valid_o), CB'(1'b1));
        reset = 1'b1;
        tick();
        check("t6_idle", CB'(busy_o), CB'(1'b0));
        check("t6_mm_valid", CB'(mm_valid_o), CB'(1'b0));
        check("t6_rsp_valid", CB'(rsp_valid), CB'(0));
        check("t6_mm_a_clr", CB'(mm_a_o), CB'(0));
        reset = 1'b0;
        req_valid = 2'b11;
        #1;
        check("t6_req0_first", CB'(req_ready), CB'(2'b01));
        sb.push_back('{id: 0, c: matmul(req_a[0], req_b[0]), err: 1'b0});
        stub_en = 1'b1;
        tick();
        req_valid = '0;
        wait_rsp("t6", c_exp);
        rsp_hs("t6", 0);

        check("sb_drained", CB'(sb.size()), CB'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_job_arbiter.md
# systolic_job_arbiter

Round-robin job arbiter and sequencer that shares one `systolicMatrixMultiply` instance between `NREQ` requesters. It accepts one job (A, B operand matrices) at a time, latches the operands, and drives the array's `valid_i`/`ready_o` handshake. It returns the product matrix to the granted requester and aborts with an error flag if the array does not respond within `TIMEOUT` cycles. It sits between the requester ports and the array, and is the only block allowed to drive the array.

## Interface
- `NREQ`, 2, number of requesters (≥2)
- `SIZE`, 32, matrix dimension, passed to the array
- `WIDTHx`, 4, operand element width
- `WIDTH`, 16, product element width
- `TIMEOUT`, 1024, max cycles in ISSUE before abort (≥ 2*SIZE+16)

Ports:
- `clock`  in  1  single clock, all logic on posedge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  NREQ  job request per requester
- `req_ready`  out  NREQ  one-hot grant/accept; reset 0
- `req_a`, `req_b`  in  NREQ×SIZE×SIZE×WIDTHx  operand matrices per requester
- `rsp_valid`  out  NREQ  one-hot result valid; reset 0
- `rsp_ready`  in  NREQ  result consumed
- `rsp_c`  out  SIZE×SIZE×WIDTH  result matrix, shared by all requesters; reset all 0
- `rsp_error`  out  1  qualifies `rsp_valid`: timeout abort; reset 0
- `mm_valid_o`  out  1  to array `valid_i`; reset 0
- `mm_ready_i`  in  1  from array `ready_o`
- `mm_a_o`, `mm_b_o`  out  SIZE×SIZE×WIDTHx  to array `a_input`/`b_input`; reset 0
- `mm_c_i`  in  SIZE×SIZE×WIDTH  from array `output_produc_a_b`
- `busy_o`  out  1  state != IDLE; reset 0
- `grant_id_o`  out  $clog2(NREQ)  requester owning the array; reset 0

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset puts the FSM in IDLE, clears all registers and sets `last_grant = NREQ-1`, so requester 0 has first priority.
- IDLE: the arbiter scans `req_valid` round-robin starting at `last_grant+1` (mod NREQ). `req_ready[g]` is asserted combinationally for the winner only. On the handshake it latches `req_a[g]`/`req_b[g]` into the `mm_a_o`/`mm_b_o` registers, sets `grant_id_o = g` and `last_grant = g`, clears the timeout counter, and moves to ISSUE.
- ISSUE:
  - `mm_valid_o = 1`.
  - If `mm_ready_i` is sampled high, capture `mm_c_i` into `rsp_c`, set `rsp_error = 0`, and go to RESP.
  - Otherwise, when the counter reaches `TIMEOUT-1`, clear `rsp_c`, set `rsp_error = 1`, and go to RESP.
  - If `mm_ready_i` and the timeout occur in the same cycle, the result wins.
- RESP: `mm_valid_o = 0` and `rsp_valid[grant_id_o] = 1`. `rsp_c` and `rsp_error` are held stable. On `rsp_ready[grant_id_o]` the FSM returns to IDLE. `rsp_ready` from other requesters is ignored.
- `req_ready` is 0 outside IDLE. Requests arriving in ISSUE/RESP wait; they are not queued.
- Operands stay in the latch registers and `mm_a_o`/`mm_b_o` remain constant for the whole of ISSUE. Requesters may change `req_a`/`req_b` after acceptance.
- Width rules: no arithmetic on data; `mm_c_i` is captured as-is at `WIDTH` bits. The timeout counter is `$clog2(TIMEOUT)` bits wide and saturates; it never wraps.
- Reset asserted in any state: on the next edge the FSM is in IDLE and all outputs are at reset values. An in-flight job is dropped and no response is generated.

## Timing
- Accept at edge T (IDLE, `req_valid & req_ready`). `mm_valid_o` is high from cycle T+1.
- `mm_ready_i` sampled high at edge R → `rsp_valid` is high from cycle R+1 and `mm_valid_o` is low from R+1. There is exactly one `mm_valid_o` high run per job.
- Timeout: `rsp_valid` with `rsp_error` rises at T+1+TIMEOUT.
- `rsp` handshake at edge S → IDLE at S+1, and the next grant is possible at edge S+1. Minimum job turnaround is 3 cycles plus array latency.
- There is no bubble between the response and a pending request of another requester beyond the IDLE cycle.

## Structure
- Package `systolic_pkg`:
  - `arb_state_t` enum (IDLE, ISSUE, RESP)
  - default `SIZE`/`WIDTH`/`WIDTHx` localparams
  - matrix element typedefs shared with the array and testbench
- Sub-module `rr_arbiter` (NREQ-wide):
  - inputs: request vector, `last_grant`, enable
  - outputs: one-hot grant, grant index
  - purely combinational
- The FSM, the latch registers, and the timeout counter are in `systolic_job_arbiter`.

## Test plan
- Reset then single job: req0, A=identity, B=all 3 → `mm_valid_o` rises at T+1; after the array's `ready_o`, `rsp_valid[0]=1`, `rsp_c` all 3, `rsp_error=0`.
- Both requesters valid continuously, 4 jobs → grants 0,1,0,1. `req_ready` is never asserted to both and never outside IDLE.
- Operand stability: req0 changes `req_a` to all 0xF one cycle after accept → `mm_a_o` keeps the accepted value through ISSUE, and the result matches the original operands.
- Timeout: stub array never raises `ready_o`, TIMEOUT=100 → `rsp_valid[g]=1` with `rsp_error=1`, `rsp_c`=0, at T+101.
- Backpressure: `rsp_ready` held 0 for 20 cycles, req1 valid meanwhile → `rsp_c` stable, `req_ready[1]=0`, req1 granted at S+1.
- Reset mid-ISSUE: reset asserted 5 cycles after accept → next cycle IDLE, `mm_valid_o=0`, no `rsp_valid`, req0 wins the next arbitration.
